// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised 2**A x W register file with scoreboard.
//
// Three combinational read ports (A, B, C), one write port that accepts a
// full-word write (WriteEn) or an immediate half-write (MovEn/MovHi/MovImm),
// optional write-to-read bypass, optional hard-wired zero register,
// per-register pending bits for in-flight loads, and a sequential clear
// engine that zeroes one register per cycle.
//
// Ports:
//   Clk, Reset                 rising-edge clock, async active-high reset
//   WriteEn, MovEn, MovHi      write controls (Mov has priority over Write)
//   Waddr, DataIn, MovImm      write address / full data / immediate field
//   RaddrA/B/C                 read addresses
//   ImmSelB                    DataOutB = {RaddrA,RaddrB} zero-extended
//   PendSet, PendAddr          mark a register as pending
//   ClearReq                   start the clear engine
//   DataOutA/B/C               read data
//   PendA/B/C                  stored pending bits of RaddrA/B/C
//   ClearBusy, ClearDone       clear engine active / one-cycle completion

module reg_file_sb #(
  parameter int W        = 8,
  parameter int A        = 2,
  parameter int IMM_W    = 4,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             WriteEn,
  input  logic             MovEn,
  input  logic             MovHi,
  input  logic [A-1:0]     Waddr,
  input  logic [W-1:0]     DataIn,
  input  logic [IMM_W-1:0] MovImm,
  input  logic [A-1:0]     RaddrA,
  input  logic [A-1:0]     RaddrB,
  input  logic [A-1:0]     RaddrC,
  input  logic             ImmSelB,
  input  logic             PendSet,
  input  logic [A-1:0]     PendAddr,
  input  logic             ClearReq,
  output logic [W-1:0]     DataOutA,
  output logic [W-1:0]     DataOutB,
  output logic [W-1:0]     DataOutC,
  output logic             PendA,
  output logic             PendB,
  output logic             PendC,
  output logic             ClearBusy,
  output logic             ClearDone
);

  localparam int            DEPTH   = 2 ** A;
  localparam bit            ZR      = (ZERO_REG != 0);
  localparam bit            BYP     = (BYPASS != 0);
  localparam logic [A-1:0]  LAST    = {A{1'b1}};
  localparam logic [A-1:0]  ADDR0   = {A{1'b0}};
  localparam logic [W-1:0]  LO_MASK = {{(W-IMM_W){1'b0}}, {IMM_W{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [A-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   regs_q [DEPTH];
  logic [W-1:0]   regs_d [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;

  logic           busy_s;
  logic           wr_eff_s;
  logic           pend_set_eff_s;
  logic [W-1:0]   wr_val_s;
  logic [W-1:0]   imm_b_s;

  // Replace the selected IMM_W field of old with imm, keeping all other bits.
  function automatic logic [W-1:0] mov_merge(input logic [W-1:0]     old,
                                             input logic [IMM_W-1:0] imm,
                                             input logic             hi);
    logic [W-1:0] mask;
    logic [W-1:0] ext;
    mask = hi ? (LO_MASK << IMM_W) : LO_MASK;
    ext  = {{(W-IMM_W){1'b0}}, imm};
    ext  = hi ? (ext << IMM_W) : ext;
    return (old & ~mask) | (ext & mask);
  endfunction

  // One read port: zero register first, then bypass, then stored value.
  function automatic logic [W-1:0] read_port(input logic [A-1:0] addr,
                                             input logic [W-1:0] stored,
                                             input logic         byp_en,
                                             input logic [A-1:0] waddr,
                                             input logic [W-1:0] wval);
    logic [W-1:0] r;
    if (ZR && (addr == ADDR0)) begin
      r = {W{1'b0}};
    end else if (BYP && byp_en && (addr == waddr)) begin
      r = wval;
    end else begin
      r = stored;
    end
    return r;
  endfunction

  assign busy_s    = (state_q == S_CLEAR);
  assign ClearBusy = busy_s;
  assign ClearDone = (state_q == S_DONE);

  // Effective write qualification and the value that lands in Reg[Waddr].
  always_comb begin
    wr_eff_s       = !busy_s && (MovEn || WriteEn) && !(ZR && (Waddr == ADDR0));
    pend_set_eff_s = !busy_s && PendSet && !(ZR && (PendAddr == ADDR0));
    wr_val_s       = MovEn ? mov_merge(regs_q[Waddr], MovImm, MovHi) : DataIn;
    imm_b_s        = W'({RaddrA, RaddrB});
  end

  // Combinational read ports; port B bypass is suppressed in immediate mode.
  always_comb begin
    DataOutA = read_port(RaddrA, regs_q[RaddrA], wr_eff_s, Waddr, wr_val_s);
    DataOutC = read_port(RaddrC, regs_q[RaddrC], wr_eff_s, Waddr, wr_val_s);
    if (ImmSelB) begin
      DataOutB = imm_b_s;
    end else begin
      DataOutB = read_port(RaddrB, regs_q[RaddrB], wr_eff_s, Waddr, wr_val_s);
    end
    PendA = pend_q[RaddrA];
    PendB = pend_q[RaddrB];
    PendC = pend_q[RaddrC];
  end

  // Next-state: write port, scoreboard, then clear FSM overrides.
  always_comb begin
    regs_d  = regs_q;
    pend_d  = pend_q;
    state_d = state_q;
    cnt_d   = cnt_q;

    if (wr_eff_s) begin
      regs_d[Waddr] = wr_val_s;
      pend_d[Waddr] = 1'b0;
    end else begin
      regs_d[Waddr] = regs_q[Waddr];
    end
    // A set on the same register as a write wins, so it is applied last.
    pend_d[PendAddr] = pend_set_eff_s ? 1'b1 : pend_d[PendAddr];

    case (state_q)
      S_IDLE: begin
        if (ClearReq) begin
          state_d = S_CLEAR;
          cnt_d   = ADDR0;
          pend_d  = {DEPTH{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        regs_d[cnt_q] = {W{1'b0}};
        // Hold cnt on the last register so it never wraps while in CLEAR.
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          cnt_d   = cnt_q;
        end else begin
          state_d = S_CLEAR;
          cnt_d   = cnt_q + {{(A-1){1'b0}}, 1'b1};
        end
      end
      S_DONE: begin
        if (ClearReq) begin
          state_d = S_CLEAR;
          cnt_d   = ADDR0;
          pend_d  = {DEPTH{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = ADDR0;
      end
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= ADDR0;
      pend_q  <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= {W{1'b0}};
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: a default instance (BYPASS=1,
// ZERO_REG=0) and a ZERO_REG=1 instance share the same stimulus.
// Expected values are queued when stimulus is driven and popped at check time.

module tb_reg_file_sb;

  logic       Clk, Reset, WriteEn, MovEn, MovHi, ImmSelB, PendSet, ClearReq;
  logic [1:0] Waddr, RaddrA, RaddrB, RaddrC, PendAddr;
  logic [7:0] DataIn;
  logic [3:0] MovImm;
  logic [7:0] DataOutA, DataOutB, DataOutC;
  logic       PendA, PendB, PendC, ClearBusy, ClearDone;
  logic [7:0] z_out_a, z_out_b, z_out_c;
  logic       z_pend_a, z_pend_b, z_pend_c, z_busy, z_done;

  logic [7:0] exp_q[$];
  logic [7:0] exp_e;
  int         vectors;
  int         miscompares;

  reg_file_sb #(.W(8), .A(2), .IMM_W(4), .BYPASS(1), .ZERO_REG(0)) u_dut (
    .Clk(Clk), .Reset(Reset), .WriteEn(WriteEn), .MovEn(MovEn), .MovHi(MovHi),
    .Waddr(Waddr), .DataIn(DataIn), .MovImm(MovImm),
    .RaddrA(RaddrA), .RaddrB(RaddrB), .RaddrC(RaddrC), .ImmSelB(ImmSelB),
    .PendSet(PendSet), .PendAddr(PendAddr), .ClearReq(ClearReq),
    .DataOutA(DataOutA), .DataOutB(DataOutB), .DataOutC(DataOutC),
    .PendA(PendA), .PendB(PendB), .PendC(PendC),
    .ClearBusy(ClearBusy), .ClearDone(ClearDone)
  );

  reg_file_sb #(.W(8), .A(2), .IMM_W(4), .BYPASS(1), .ZERO_REG(1)) u_dut_z (
    .Clk(Clk), .Reset(Reset), .WriteEn(WriteEn), .MovEn(MovEn), .MovHi(MovHi),
    .Waddr(Waddr), .DataIn(DataIn), .MovImm(MovImm),
    .RaddrA(RaddrA), .RaddrB(RaddrB), .RaddrC(RaddrC), .ImmSelB(ImmSelB),
    .PendSet(PendSet), .PendAddr(PendAddr), .ClearReq(ClearReq),
    .DataOutA(z_out_a), .DataOutB(z_out_b), .DataOutC(z_out_c),
    .PendA(z_pend_a), .PendB(z_pend_b), .PendC(z_pend_c),
    .ClearBusy(z_busy), .ClearDone(z_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic idle_inputs();
    WriteEn = 1'b0; MovEn = 1'b0; MovHi = 1'b0; ImmSelB = 1'b0;
    PendSet = 1'b0; ClearReq = 1'b0; Waddr = 2'd0; RaddrA = 2'd0;
    RaddrB = 2'd0; RaddrC = 2'd0; PendAddr = 2'd0; DataIn = 8'h00; MovImm = 4'h0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
    WriteEn = 1'b1; Waddr = a; DataIn = d;
    tick();
    WriteEn = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    idle_inputs();
    #1;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_e = exp_q.pop_front(); vectors++;
    if (DataOutA !== exp_e) begin miscompares++; $display("FAIL rst_out_a: got %h want %h", DataOutA, exp_e); end
    exp_e = exp_q.pop_front(); vectors++;
    if (DataOutB !== exp_e) begin miscompares++; $display("FAIL rst_out_b: got %h want %h", DataOutB, exp_e); end
    exp_e = exp_q.pop_front(); vectors++;
    if (DataOutC !== exp_e) begin miscompares++; $display("FAIL rst_out_c: got %h want %h", DataOutC, exp_e); end
    exp_e = exp_q.pop_front(); vectors++;
    if ({7'd0, ClearBusy} !== exp_e) begin miscompares++; $display("FAIL rst_busy: got %h want %h", ClearBusy, exp_e); end
    exp_e = exp_q.pop_front(); vectors++;
    if ({7'd0, ClearDone} !== exp_e) begin miscompares++; $display("FAIL rst_done: got %h want %h", ClearDone, exp_e); end
    ImmSelB = 1'b1; RaddrA = 2'd2; RaddrB = 2'd1;
    exp_q.push_back(8'h09);
    #1;
    exp_e = exp_q.pop_front(); vectors++;
    if (DataOutB !== exp_e) begin miscompares++; $display("FAIL rst_immsel_b: got %h want %h", DataOutB, exp_e); end
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_write_read();
    exp_q.push_back(8'hA5); exp_q.push_back(8'h00);
    write_reg(2'd2, 8'hA5);
    RaddrA = 2'd2; RaddrB = 2'd3;
    #1;
    exp_e = exp_q.pop_front(); vectors++;
    if (DataOutA !== exp_e) begin miscompares++; $display("FAIL wr_rd_a: got %h want %h", DataOutA, exp_e); end
    exp_e = exp_q.pop_front(); vectors++;
    if (DataOutB !== exp_e) begin miscompares++; $display("FAIL wr_rd_b: got %h want %h", DataOutB, exp_e); end
  endtask

  task automatic test_mov();
    write_reg(2'd1, 8'hF0);
    MovEn = 1'b1; MovHi = 1'b0; MovImm = 4'h3; Waddr = 2'd1; RaddrC = 2'd1;
    exp_q.push_back(8'hF3);
    #1;
    exp_e = exp_q.pop_front(); vectors++;
    if (DataOutC !== exp_e) begin miscompares++; $display("FAIL mov_lo_bypass: got %h want %h", DataOutC, exp_e); end
    tick();
    MovEn = 1'b0; RaddrA = 2'd1;
    exp_q.push_back(8'hF3);
    #1;
    exp_e = exp_q.pop_front(); vectors++;
    if (DataOutA !== exp_e) begin miscompares++; $display("FAIL mov_lo: got %h want %h", DataOutA, exp_e); end
    MovEn = 1'b1; MovHi = 1'b1; MovImm = 4'h6;
    exp_q.push_back(8'h63);
    tick();
    MovEn = 1'b0;
    exp_e = exp_q.pop_front(); vectors++;
    if (DataOutA !== exp_e) begin miscompares++; $display("FAIL mov_hi: got %h want %h", DataOutA, exp_e); end
    MovEn = 1'b1; MovHi = 1'b0; MovImm = 4'hA; WriteEn = 1'b1; DataIn = 8'hFF;
    exp_q.push_back(8'h6A);
    tick();
    MovEn = 1'b0; WriteEn = 1'b0;
    exp_e = exp_q.pop_front(); vectors++;
    if (DataOutA !== exp_e) begin miscompares++; $display("FAIL mov_over_write: got %h want %h", DataOutA, exp_e); end
  endtask

  task automatic test_bypass();
    WriteEn = 1'b1; Waddr = 2'd3; DataIn = 8'h5C; RaddrC = 2'd3;
    exp_q.push_back(8'h5C);
    #1;
    exp_e = exp_q.pop_front(); vectors++;
    if (DataOutC !== exp_e) begin miscompares++; $display("FAIL bypass_c: got %h want %h", DataOutC, exp_e); end
    tick();
    // Immediate mode on B must not be overridden by a bypass to address 1.
    WriteEn = 1'b1; Waddr = 2'd1; DataIn = 8'h33;
    ImmSelB = 1'b1; RaddrA = 2'd2; RaddrB = 2'd1;
    exp_q.push_back(8'h09);
    #1;
    exp_e = exp_q.pop_front(); vectors++;
    if (DataOutB !== exp_e) begin miscompares++; $display("FAIL immsel_b: got %h want %h", DataOutB, exp_e); end
    tick();
    ImmSelB = 1'b0;
    WriteEn = 1'b1; Waddr = 2'd0; DataIn = 8'h77; RaddrC = 2'd0;
    exp_q.push_back(8'h77); exp_q.push_back(8'h00);
    #1;
    exp_e = exp_q.pop_front(); vectors++;
    if (DataOutC !== exp_e) begin miscompares++; $display("FAIL bypass_r0: got %h want %h", DataOutC, exp_e); end
    exp_e = exp_q.pop_front(); vectors++;
    if (z_out_c !== exp_e) begin miscompares++; $display("FAIL zero_bypass_r0: got %h want %h", z_out_c, exp_e); end
    tick();
    WriteEn = 1'b0;
    exp_q.push_back(8'h77); exp_q.push_back(8'h00);
    #1;
    exp_e = exp_q.pop_front(); vectors++;
    if (DataOutC !== exp_e) begin miscompares++; $display("FAIL stored_r0: got %h want %h", DataOutC, exp_e); end
    exp_e = exp_q.pop_front(); vectors++;
    if (z_out_c !== exp_e) begin miscompares++; $display("FAIL zero_stored_r0: got %h want %h", z_out_c, exp_e); end
  endtask

  task automatic test_pend();
    PendSet = 1'b1; PendAddr = 2'd1;
    tick();
    PendSet = 1'b0; RaddrB = 2'd1;
    exp_q.push_back(8'h01);
    #1;
    exp_e = exp_q.pop_front(); vectors++;
    if ({7'd0, PendB} !== exp_e) begin miscompares++; $display("FAIL pend_set: got %h want %h", PendB, exp_e); end
    WriteEn = 1'b1; Waddr = 2'd1; DataIn = 8'h12;
    exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    #1;
    exp_e = exp_q.pop_front(); vectors++;
    if ({7'd0, PendB} !== exp_e) begin miscompares++; $display("FAIL pend_no_bypass: got %h want %h", PendB, exp_e); end
    tick();
    WriteEn = 1'b0;
    exp_e = exp_q.pop_front(); vectors++;
    if ({7'd0, PendB} !== exp_e) begin miscompares++; $display("FAIL pend_clr_by_write: got %h want %h", PendB, exp_e); end
    WriteEn = 1'b1; Waddr = 2'd1; DataIn = 8'h34; PendSet = 1'b1; PendAddr = 2'd1;
    exp_q.push_back(8'h01);
    tick();
    WriteEn = 1'b0; PendSet = 1'b0;
    exp_e = exp_q.pop_front(); vectors++;
    if ({7'd0, PendB} !== exp_e) begin miscompares++; $display("FAIL pend_set_wins: got %h want %h", PendB, exp_e); end
    PendSet = 1'b1; PendAddr = 2'd0;
    exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    tick();
    PendSet = 1'b0; RaddrA = 2'd0;
    #1;
    exp_e = exp_q.pop_front(); vectors++;
    if ({7'd0, PendA} !== exp_e) begin miscompares++; $display("FAIL pend_r0: got %h want %h", PendA, exp_e); end
    exp_e = exp_q.pop_front(); vectors++;
    if ({7'd0, z_pend_a} !== exp_e) begin miscompares++; $display("FAIL zero_pend_r0: got %h want %h", z_pend_a, exp_e); end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 4; i++) begin
      write_reg(i[1:0], 8'hFF);
    end
    PendSet = 1'b1; PendAddr = 2'd2;
    tick();
    PendSet = 1'b0;
    ClearReq = 1'b1;
    tick();
    ClearReq = 1'b0;
    for (int k = 0; k < 4; k++) begin
      // Writes and pending sets issued mid-clear must be dropped.
      WriteEn = (k == 1); Waddr = 2'd0; DataIn = 8'h11;
      PendSet = (k == 1); PendAddr = 2'd3;
      exp_q.push_back(8'h01);
      #1;
      exp_e = exp_q.pop_front(); vectors++;
      if ({7'd0, ClearBusy} !== exp_e) begin miscompares++; $display("FAIL clear_busy_%0d: got %h want %h", k, ClearBusy, exp_e); end
      tick();
    end
    WriteEn = 1'b0; PendSet = 1'b0;
    exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    exp_e = exp_q.pop_front(); vectors++;
    if ({7'd0, ClearBusy} !== exp_e) begin miscompares++; $display("FAIL clear_busy_end: got %h want %h", ClearBusy, exp_e); end
    exp_e = exp_q.pop_front(); vectors++;
    if ({7'd0, ClearDone} !== exp_e) begin miscompares++; $display("FAIL clear_done: got %h want %h", ClearDone, exp_e); end
    tick();
    exp_e = exp_q.pop_front(); vectors++;
    if ({7'd0, ClearDone} !== exp_e) begin miscompares++; $display("FAIL clear_done_pulse: got %h want %h", ClearDone, exp_e); end
    for (int a = 0; a < 4; a++) begin
      RaddrA = a[1:0];
      exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      #1;
      exp_e = exp_q.pop_front(); vectors++;
      if (DataOutA !== exp_e) begin miscompares++; $display("FAIL clear_reg_%0d: got %h want %h", a, DataOutA, exp_e); end
      exp_e = exp_q.pop_front(); vectors++;
      if ({7'd0, PendA} !== exp_e) begin miscompares++; $display("FAIL clear_pend_%0d: got %h want %h", a, PendA, exp_e); end
    end
  endtask

  task automatic test_reset_mid_clear();
    write_reg(2'd1, 8'hFF);
    write_reg(2'd2, 8'hFF);
    write_reg(2'd3, 8'hFF);
    ClearReq = 1'b1;
    tick();
    ClearReq = 1'b0;
    tick();
    RaddrA = 2'd1; RaddrB = 2'd2; RaddrC = 2'd3; ImmSelB = 1'b0;
    exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
    #1;
    exp_e = exp_q.pop_front(); vectors++;
    if (DataOutA !== exp_e) begin miscompares++; $display("FAIL pre_rst_a: got %h want %h", DataOutA, exp_e); end
    exp_e = exp_q.pop_front(); vectors++;
    if ({7'd0, ClearBusy} !== exp_e) begin miscompares++; $display("FAIL pre_rst_busy: got %h want %h", ClearBusy, exp_e); end
    #1;
    Reset = 1'b1;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    #1;
    exp_e = exp_q.pop_front(); vectors++;
    if ({7'd0, ClearBusy} !== exp_e) begin miscompares++; $display("FAIL midrst_busy: got %h want %h", ClearBusy, exp_e); end
    exp_e = exp_q.pop_front(); vectors++;
    if (DataOutA !== exp_e) begin miscompares++; $display("FAIL midrst_a: got %h want %h", DataOutA, exp_e); end
    exp_e = exp_q.pop_front(); vectors++;
    if (DataOutB !== exp_e) begin miscompares++; $display("FAIL midrst_b: got %h want %h", DataOutB, exp_e); end
    exp_e = exp_q.pop_front(); vectors++;
    if (DataOutC !== exp_e) begin miscompares++; $display("FAIL midrst_c: got %h want %h", DataOutC, exp_e); end
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_write_read();
    test_mov();
    test_bypass();
    test_pend();
    test_clear();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
